// File: rtl/mem_io_pkg.sv
// Shared types and constants for the SLC-3 memory/IO bridge.
// State encodings are plain constants so older code that compares raw bits keeps working.
package mem_io_pkg;

    localparam int unsigned WAIT_W = 4;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef logic [1:0] bridge_state_t;

    localparam bridge_state_t IDLE   = 2'd0;
    localparam bridge_state_t ACCESS = 2'd1;
    localparam bridge_state_t DONE   = 2'd2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs such as board switches.
// The output lags the input by two clock edges.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-side bridge: single-pulse requests to SRAM with configurable wait states, plus a
// memory-mapped switch input and hex-display register at IO_ADDR.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int unsigned        DATA_W      = 16,
    parameter int unsigned        ADDR_W      = 16,
    parameter int unsigned        MEM_ADDR_W  = 10,
    parameter int unsigned        WAIT_STATES = 1,
    parameter int unsigned        NUM_HEX     = 4,
    parameter int unsigned        SW_W        = 10,
    parameter logic [ADDR_W-1:0]  IO_ADDR     = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Req,
    input  logic                   We,
    input  logic [ADDR_W-1:0]      Addr,
    input  logic [DATA_W-1:0]      Wdata,
    output logic [DATA_W-1:0]      Rdata,
    output logic                   Ready,
    output logic                   Busy,
    input  logic [SW_W-1:0]        Switches,
    output logic [4*NUM_HEX-1:0]   Hex_out,
    output logic [MEM_ADDR_W-1:0]  Sram_addr,
    output logic [DATA_W-1:0]      Sram_wdata,
    input  logic [DATA_W-1:0]      Sram_rdata,
    output logic                   Sram_oe,
    output logic                   Sram_we
);

    bridge_state_t           state_q, state_d;
    logic [WAIT_W-1:0]       cnt_q;
    logic                    we_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [4*NUM_HEX-1:0]    hex_q;
    logic [MEM_ADDR_W-1:0]   sram_addr_q;
    logic [DATA_W-1:0]       sram_wdata_q;
    logic [SW_W-1:0]         sw_sync;

    logic accept;
    logic is_io;
    logic access_last;

    sync_2ff #(
        .WIDTH (SW_W)
    ) u_sw_sync (
        .clk   (Clk),
        .rst_n (Reset_n),
        .d     (Switches),
        .q     (sw_sync)
    );

    // Requests are only seen in IDLE, so anything arriving while busy or in DONE is dropped.
    assign accept      = (state_q == IDLE) && Req;
    assign is_io       = (Addr == IO_ADDR);
    assign access_last = (state_q == ACCESS) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Req) state_d = is_io ? DONE : ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q <= We;
                if (!is_io) begin
                    sram_addr_q  <= Addr[MEM_ADDR_W-1:0];
                    sram_wdata_q <= Wdata;
                    cnt_q        <= WAIT_W'(WAIT_STATES);
                end
            end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Rdata only moves on a completing read; writes and idle cycles leave it alone.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            if (access_last && !we_q) begin
                rdata_q <= Sram_rdata;
            end else if (accept && is_io && !We) begin
                rdata_q <= DATA_W'(sw_sync);
            end
            if (accept && is_io && We) begin
                hex_q <= Wdata[4*NUM_HEX-1:0];
            end
        end
    end

    // Strobes decode straight from state so they drop the instant reset asserts.
    assign Sram_oe    = (state_q == ACCESS) && !we_q;
    assign Sram_we    = (state_q == ACCESS) && we_q;
    assign Ready      = (state_q == DONE);
    assign Busy       = (state_q != IDLE);
    assign Rdata      = rdata_q;
    assign Hex_out    = hex_q;
    assign Sram_addr  = sram_addr_q;
    assign Sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: WAIT_STATES=2 instance with an SRAM model,
// plus a WAIT_STATES=0 instance for the zero-wait latency case.
module tb_mem_io_bridge;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_n, Req, Req0, We;
    logic [15:0] Addr, Wdata;
    logic [9:0]  Switches;

    logic [15:0] Rdata, Hex_out, Sram_wdata, Sram_rdata;
    logic        Ready, Busy, Sram_oe, Sram_we;
    logic [9:0]  Sram_addr;

    logic [15:0] Rdata0, Hex_out0, Sram_wdata0, Sram_rdata0;
    logic        Ready0, Busy0, Sram_oe0, Sram_we0;
    logic [9:0]  Sram_addr0;

    logic [15:0] mem [0:1023];
    assign Sram_rdata  = mem[Sram_addr];
    assign Sram_rdata0 = 16'hC3A5;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int oe_cnt = 0;
    int we0, oe0;

    mem_io_bridge #(
        .WAIT_STATES (2)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Req        (Req),
        .We         (We),
        .Addr       (Addr),
        .Wdata      (Wdata),
        .Rdata      (Rdata),
        .Ready      (Ready),
        .Busy       (Busy),
        .Switches   (Switches),
        .Hex_out    (Hex_out),
        .Sram_addr  (Sram_addr),
        .Sram_wdata (Sram_wdata),
        .Sram_rdata (Sram_rdata),
        .Sram_oe    (Sram_oe),
        .Sram_we    (Sram_we)
    );

    mem_io_bridge #(
        .WAIT_STATES (0)
    ) dut0 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Req        (Req0),
        .We         (We),
        .Addr       (Addr),
        .Wdata      (Wdata),
        .Rdata      (Rdata0),
        .Ready      (Ready0),
        .Busy       (Busy0),
        .Switches   (Switches),
        .Hex_out    (Hex_out0),
        .Sram_addr  (Sram_addr0),
        .Sram_wdata (Sram_wdata0),
        .Sram_rdata (Sram_rdata0),
        .Sram_oe    (Sram_oe0),
        .Sram_we    (Sram_we0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sram_model();
        forever begin
            @(posedge Clk);
            cyc++;
            if (Sram_we) mem[Sram_addr] = Sram_wdata;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Sram_we) we_cnt++;
            if (Sram_oe) oe_cnt++;
            if (Ready) begin
                check("ready_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rdata", Rdata, e.rdata);
                    check("ready_cycle", cyc, e.cyc);
                    check("busy_at_ready", Busy, 1);
                end
            end
        end
    endtask

    // Drives one request at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] er, input int lat, input bit push);
        Req = 1'b1; We = w; Addr = a; Wdata = d;
        if (push) exp_q.push_back('{er, cyc + lat});
        @(negedge Clk);
        Req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check({name, "_idle_timeout"}, Busy, 0);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        Reset_n = 1'b0; Req = 1'b0; Req0 = 1'b0; We = 1'b0;
        Addr = '0; Wdata = '0; Switches = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[5] = 16'h5A5A;
        fork
            sram_model();
            monitor();
        join_none

        // T1: requests under reset are ignored and everything reads zero
        repeat (2) @(negedge Clk);
        Req = 1'b1; We = 1'b1; Addr = 16'h0012; Wdata = 16'hAAAA;
        @(negedge Clk);
        check("t1_busy", Busy, 0);
        check("t1_ready", Ready, 0);
        check("t1_rdata", Rdata, 0);
        check("t1_hex", Hex_out, 0);
        check("t1_sram_addr", Sram_addr, 0);
        check("t1_sram_wdata", Sram_wdata, 0);
        check("t1_oe", Sram_oe, 0);
        check("t1_we", Sram_we, 0);
        Req = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clk);
        issue(1'b0, 16'h0005, 16'h0000, 16'h5A5A, 4, 1'b1);
        check("t1_accept_busy", Busy, 1);
        wait_idle("t1");

        // T2: SRAM write, three ACCESS cycles
        we0 = we_cnt; oe0 = oe_cnt;
        issue(1'b1, 16'h0012, 16'hBEEF, 16'h5A5A, 4, 1'b1);
        check("t2_we", Sram_we, 1);
        check("t2_addr", Sram_addr, 10'h012);
        check("t2_wdata", Sram_wdata, 16'hBEEF);
        wait_idle("t2");
        check("t2_we_cycles", we_cnt - we0, 3);
        check("t2_oe_cycles", oe_cnt - oe0, 0);
        check("t2_mem", mem[10'h012], 16'hBEEF);

        // T3: aliased read returns the T2 data
        we0 = we_cnt; oe0 = oe_cnt;
        issue(1'b0, 16'h0412, 16'h0000, 16'hBEEF, 4, 1'b1);
        check("t3_addr_alias", Sram_addr, 10'h012);
        check("t3_oe", Sram_oe, 1);
        check("t3_we", Sram_we, 0);
        wait_idle("t3");
        check("t3_we_cycles", we_cnt - we0, 0);
        check("t3_oe_cycles", oe_cnt - oe0, 3);

        // T4: IO switch read then hex write
        we0 = we_cnt; oe0 = oe_cnt;
        Switches = 10'h006;
        repeat (2) @(negedge Clk);
        issue(1'b0, 16'hFFFF, 16'h0000, 16'h0006, 1, 1'b1);
        wait_idle("t4_rd");
        issue(1'b1, 16'hFFFF, 16'h1234, 16'h0006, 1, 1'b1);
        wait_idle("t4_wr");
        check("t4_hex", Hex_out, 16'h1234);
        check("t4_we_cycles", we_cnt - we0, 0);
        check("t4_oe_cycles", oe_cnt - oe0, 0);
        check("t4_sram_addr_kept", Sram_addr, 10'h012);

        // T5: Req during ACCESS and during DONE are both dropped
        issue(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 4, 1'b1);
        Req = 1'b1; We = 1'b1; Addr = 16'h0020; Wdata = 16'hDEAD;
        @(negedge Clk);
        Req = 1'b0;
        check("t5_addr_kept", Sram_addr, 10'h012);
        check("t5_still_read", Sram_oe, 1);
        n = 0;
        while (!Ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("t5_ready_seen", Ready, 1);
        Req = 1'b1; We = 1'b1; Addr = 16'h0030; Wdata = 16'h5555;
        @(negedge Clk);
        Req = 1'b0;
        check("t5_done_req_ignored", Busy, 0);
        repeat (6) @(negedge Clk);
        check("t5_mem20", mem[10'h020], 16'h0000);
        check("t5_mem30", mem[10'h030], 16'h0000);
        check("t5_queue_empty", exp_q.size(), 0);

        // T6: reset mid-write aborts the access asynchronously
        issue(1'b1, 16'h0040, 16'h7777, 16'h0000, 0, 1'b0);
        check("t6_we_before", Sram_we, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("t6_we_async", Sram_we, 0);
        check("t6_oe_async", Sram_oe, 0);
        check("t6_busy_async", Busy, 0);
        check("t6_rdata_reset", Rdata, 0);
        check("t6_hex_reset", Hex_out, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("t6_busy_after", Busy, 0);
        check("t6_ready_after", Ready, 0);
        check("t6_mem40", mem[10'h040], 16'h0000);
        @(negedge Clk);
        issue(1'b0, 16'hFFFF, 16'h0000, 16'h0006, 1, 1'b1);
        wait_idle("t6");

        // WAIT_STATES=0: one ACCESS cycle, Ready in cycle 2
        We = 1'b0; Addr = 16'h0007; Req0 = 1'b1;
        @(negedge Clk);
        Req0 = 1'b0;
        check("ws0_oe_c1", Sram_oe0, 1);
        check("ws0_addr_c1", Sram_addr0, 10'h007);
        check("ws0_ready_c1", Ready0, 0);
        check("ws0_busy_c1", Busy0, 1);
        @(negedge Clk);
        check("ws0_ready_c2", Ready0, 1);
        check("ws0_rdata_c2", Rdata0, 16'hC3A5);
        check("ws0_oe_c2", Sram_oe0, 0);
        @(negedge Clk);
        check("ws0_idle_c3", Busy0, 0);
        check("ws0_we_never", Sram_we0, 0);
        check("ws0_hex", Hex_out0, 0);
        check("ws0_wdata", Sram_wdata0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
